act_buf_reader: RTL and testbench

ACT_BUF_READER -- requirements
Module: act_buf_reader

---
 rtl/act_buf_pkg.sv | 18 +
 rtl/act_word_unpack.sv | 74 +++++++
 rtl/act_buf_reader.sv | 113 +++++++++++
 tb/tb_act_buf_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/act_buf_pkg.sv
// Shared definitions for the activation-buffer read and write sides:
// FSM state encoding and the bytes-per-word relation.
package act_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    RELEASE = 2'd2
  } act_state_e;

  function automatic int bytesPerWord(input int dwidth);
    return dwidth / 8;
  endfunction

  localparam int ACT_DWIDTH     = 16;
  localparam int BYTES_PER_WORD = bytesPerWord(ACT_DWIDTH);

endpackage

// File: rtl/act_word_unpack.sv
// Two-slot word holder (unpack register + prefetch slot) feeding a
// low-byte-first byte selector with a valid/ready handshake.
module act_word_unpack
  import act_buf_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int BPW    = bytesPerWord(DWIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wordValid,
  input  logic [DWIDTH-1:0] i_word,
  input  logic              i_wordLast,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [7:0]        o_data,
  output logic              o_last,
  output logic              o_wordDone,
  output logic [1:0]        o_slotCount
);
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);

  logic              r_aValid, r_aLast, r_bValid, r_bLast;
  logic [DWIDTH-1:0] r_aWord, r_bWord;
  logic [IDXW-1:0]   r_byteIdx;
  logic              w_xfer, w_aFree;

  assign w_xfer      = r_aValid & i_ready;
  assign o_wordDone  = w_xfer & (r_byteIdx == LAST_IDX);
  assign w_aFree     = ~r_aValid | o_wordDone;
  assign o_valid     = r_aValid;
  assign o_data      = r_aValid ? r_aWord[7:0] : 8'h00;
  assign o_last      = r_aValid & r_aLast & (r_byteIdx == LAST_IDX);
  assign o_slotCount = {1'b0, r_aValid} + {1'b0, r_bValid};

  // The unpack register shifts right so the current byte is always bits 7:0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aValid  <= 1'b0;
      r_aLast   <= 1'b0;
      r_aWord   <= '0;
      r_bValid  <= 1'b0;
      r_bLast   <= 1'b0;
      r_bWord   <= '0;
      r_byteIdx <= '0;
    end else if (w_aFree) begin
      r_byteIdx <= '0;
      if (r_bValid) begin
        r_aValid <= 1'b1;
        r_aWord  <= r_bWord;
        r_aLast  <= r_bLast;
        r_bValid <= i_wordValid;
        r_bWord  <= i_word;
        r_bLast  <= i_wordLast;
      end else begin
        r_aValid <= i_wordValid;
        r_aWord  <= i_word;
        r_aLast  <= i_wordLast;
      end
    end else begin
      if (w_xfer) begin
        r_aWord   <= r_aWord >> 8;
        r_byteIdx <= r_byteIdx + 1'b1;
      end
      if (i_wordValid) begin
        r_bValid <= 1'b1;
        r_bWord  <= i_word;
        r_bLast  <= i_wordLast;
      end
    end
  end

endmodule

// File: rtl/act_buf_reader.sv
// Streams one full BRAM activation buffer as AXI-stream bytes per accepted token.
// Define ACT_READER_TLAST_EN to add the ActOut_V_TLAST output.
module act_buf_reader
  import act_buf_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 13,
  parameter int NUM_WORDS = 8192
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              SyncSig_V,
  input  logic              SyncSig_V_ap_vld,
  output logic              SyncSig_V_ap_ack,
  output logic [AWIDTH-1:0] ActBuf_Data_address0,
  output logic              ActBuf_Data_ce0,
  input  logic [DWIDTH-1:0] ActBuf_Data_q0,
  output logic [7:0]        ActOut_V_TDATA,
  output logic              ActOut_V_TVALID,
  input  logic              ActOut_V_TREADY
`ifdef ACT_READER_TLAST_EN
  ,
  output logic              ActOut_V_TLAST
`endif
);
  localparam int BPW = bytesPerWord(DWIDTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

  act_state_e        r_state, w_nextState;
  logic [AWIDTH-1:0] r_addr;
  logic              r_issueDone, r_rdPending, r_rdLast;
  logic              w_streaming, w_ready, w_valid, w_last, w_wordDone;
  logic              w_lastXfer, w_canIssue, w_accept;
  logic [7:0]        w_data;
  logic [1:0]        w_slotCount;
  logic [2:0]        w_committed;

  assign w_streaming = (r_state == STREAM);
  assign w_ready     = ActOut_V_TREADY & w_streaming;
  assign w_lastXfer  = w_last & w_ready;
  assign w_accept    = SyncSig_V_ap_vld & SyncSig_V;

  // A slot emptied by this cycle's final byte is free by the time the read data returns
  assign w_committed = {1'b0, w_slotCount} + {2'b00, r_rdPending} - {2'b00, w_wordDone};
  assign w_canIssue  = w_streaming & ~r_issueDone & (w_committed < 3'd2);

  assign ActBuf_Data_address0 = r_addr;
  assign ActOut_V_TVALID      = w_valid & w_streaming;
  assign ActOut_V_TDATA       = w_data;
`ifdef ACT_READER_TLAST_EN
  assign ActOut_V_TLAST       = w_last & w_streaming;
`endif

  always_comb begin
    w_nextState      = r_state;
    SyncSig_V_ap_ack = 1'b0;
    ActBuf_Data_ce0  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = STREAM;
      end
      STREAM: begin
        ActBuf_Data_ce0 = w_canIssue;
        if (w_lastXfer) w_nextState = RELEASE;
      end
      RELEASE: begin
        SyncSig_V_ap_ack = 1'b1;
        w_nextState      = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A separate done flag ends the read sweep so a full 2^AWIDTH buffer never wraps
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_issueDone <= 1'b0;
      r_rdPending <= 1'b0;
      r_rdLast    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_rdPending <= ActBuf_Data_ce0;
      r_rdLast    <= ActBuf_Data_ce0 & (r_addr == LAST_ADDR);
      if (r_state != STREAM) begin
        r_addr      <= '0;
        r_issueDone <= 1'b0;
      end else if (ActBuf_Data_ce0) begin
        r_addr <= r_addr + 1'b1;
        if (r_addr == LAST_ADDR) r_issueDone <= 1'b1;
      end
    end
  end

  act_word_unpack #(
    .DWIDTH (DWIDTH),
    .BPW    (BPW)
  ) u_unpack (
    .i_clk       (ap_clk),
    .i_rst       (ap_rst),
    .i_wordValid (r_rdPending),
    .i_word      (ActBuf_Data_q0),
    .i_wordLast  (r_rdLast),
    .i_ready     (w_ready),
    .o_valid     (w_valid),
    .o_data      (w_data),
    .o_last      (w_last),
    .o_wordDone  (w_wordDone),
    .o_slotCount (w_slotCount)
  );

endmodule

// File: tb/tb_act_buf_reader.sv
// Scoreboard bench for act_buf_reader (AWIDTH=3, NUM_WORDS=8): reference byte/address
// streams are queued per token and a negedge monitor checks every DUT cycle.
module tb_act_buf_reader;
  import act_buf_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int NW  = 8;
  localparam int BPW = bytesPerWord(DW);

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          SyncSig_V = 1'b0;
  logic          SyncSig_V_ap_vld = 1'b0;
  logic          SyncSig_V_ap_ack;
  logic [AW-1:0] ActBuf_Data_address0;
  logic          ActBuf_Data_ce0;
  logic [DW-1:0] ActBuf_Data_q0;
  logic [7:0]    ActOut_V_TDATA;
  logic          ActOut_V_TVALID;
  logic          ActOut_V_TREADY = 1'b0;
`ifdef ACT_READER_TLAST_EN
  logic          ActOut_V_TLAST;
`endif

  int         testsRun = 0;
  int         testsFailed = 0;
  int         cycle = 0;
  logic [DW-1:0] mem [NW];
  logic [7:0] expByteQ[$];
  bit         expLastQ[$];
  int         expAddrQ[$];
  int         readyMode = 0;
  int         readyPhase = 0;
  int         acceptCycle = -100;
  bit         awaitFirst = 1'b0;
  int         lastXferCycle = -100;
  int         firstByteCycle = -100;
  int         bytesSeen = 0;
  bit         prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  act_buf_reader #(
    .DWIDTH    (DW),
    .AWIDTH    (AW),
    .NUM_WORDS (NW)
  ) dut (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .SyncSig_V            (SyncSig_V),
    .SyncSig_V_ap_vld     (SyncSig_V_ap_vld),
    .SyncSig_V_ap_ack     (SyncSig_V_ap_ack),
    .ActBuf_Data_address0 (ActBuf_Data_address0),
    .ActBuf_Data_ce0      (ActBuf_Data_ce0),
    .ActBuf_Data_q0       (ActBuf_Data_q0),
    .ActOut_V_TDATA       (ActOut_V_TDATA),
    .ActOut_V_TVALID      (ActOut_V_TVALID),
    .ActOut_V_TREADY      (ActOut_V_TREADY)
`ifdef ACT_READER_TLAST_EN
    ,
    .ActOut_V_TLAST       (ActOut_V_TLAST)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cycle <= cycle + 1;

  // BRAM model: one-cycle read latency
  always @(posedge ap_clk) if (ActBuf_Data_ce0) ActBuf_Data_q0 <= mem[ActBuf_Data_address0];

  // Sink readiness: 0 = always ready, 1 = pattern 1,0,0,1, other = random
  always @(posedge ap_clk) begin
    #1;
    case (readyMode)
      0: ActOut_V_TREADY = 1'b1;
      1: begin
        ActOut_V_TREADY = (readyPhase == 0) || (readyPhase == 3);
        readyPhase = (readyPhase + 1) % 4;
      end
      default: ActOut_V_TREADY = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  always @(negedge ap_clk) begin
    logic [7:0] eb;
    bit el;
    if (!ap_rst) begin
      if (expAddrQ.size() == 0)
        checkOutput("ce0_without_pending_read", ActBuf_Data_ce0, 0);
      else if (ActBuf_Data_ce0)
        checkOutput("bram_address", ActBuf_Data_address0, expAddrQ.pop_front());

      if (prevStall) begin
        checkOutput("stall_tvalid_held", ActOut_V_TVALID, 1);
        checkOutput("stall_tdata_held", ActOut_V_TDATA, prevData);
      end

      if (ActOut_V_TVALID && awaitFirst) begin
        awaitFirst = 1'b0;
        testsRun++;
        if (cycle - acceptCycle > 3) begin
          testsFailed++;
          $display("[TB] FAIL first_tvalid_latency: got %0d cycles, required at most 3",
                   cycle - acceptCycle);
        end
      end

      if (expByteQ.size() == 0)
        checkOutput("tvalid_without_pending_byte", ActOut_V_TVALID, 0);
      else if (ActOut_V_TVALID && ActOut_V_TREADY) begin
        eb = expByteQ.pop_front();
        el = expLastQ.pop_front();
        checkOutput("tdata", ActOut_V_TDATA, eb);
`ifdef ACT_READER_TLAST_EN
        checkOutput("tlast", ActOut_V_TLAST, el);
`endif
        if (bytesSeen == 0) firstByteCycle = cycle;
        if (el) lastXferCycle = cycle;
        bytesSeen++;
      end

      checkOutput("ack", SyncSig_V_ap_ack, (cycle == lastXferCycle + 1));
      prevStall = ActOut_V_TVALID && !ActOut_V_TREADY;
      prevData  = ActOut_V_TDATA;
    end else begin
      prevStall = 1'b0;
    end
  end

  // Loads a buffer, queues its reference streams and presents a full-buffer token
  task automatic applyStimulus(input int mode, input bit fixedData);
    readyMode = mode;
    for (int w = 0; w < NW; w++) begin
      mem[w] = fixedData ? DW'(((2 * w + 2) << 8) | (2 * w + 1)) : DW'($urandom);
      expAddrQ.push_back(w);
      for (int b = 0; b < BPW; b++) begin
        expByteQ.push_back(8'(mem[w] >> (8 * b)));
        expLastQ.push_back((w == NW - 1) && (b == BPW - 1));
      end
    end
    bytesSeen = 0;
    @(posedge ap_clk);
    #1;
    SyncSig_V        = 1'b1;
    SyncSig_V_ap_vld = 1'b1;
    acceptCycle      = cycle;
    awaitFirst       = 1'b1;
  endtask

  task automatic waitRelease();
    bit gotAck = 1'b0;
    for (int i = 0; i < 400 && !gotAck; i++) begin
      @(negedge ap_clk);
      if (SyncSig_V_ap_ack) gotAck = 1'b1;
    end
    SyncSig_V_ap_vld = 1'b0;
    SyncSig_V        = 1'b0;
    checkOutput("ack_received", gotAck, 1);
    checkOutput("bytes_outstanding", expByteQ.size(), 0);
    checkOutput("reads_outstanding", expAddrQ.size(), 0);
    expByteQ.delete();
    expLastQ.delete();
    expAddrQ.delete();
    awaitFirst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    checkOutput("reset_tvalid", ActOut_V_TVALID, 0);
    checkOutput("reset_tdata", ActOut_V_TDATA, 0);
    checkOutput("reset_ce0", ActBuf_Data_ce0, 0);
    checkOutput("reset_address0", ActBuf_Data_address0, 0);
    checkOutput("reset_ack", SyncSig_V_ap_ack, 0);
`ifdef ACT_READER_TLAST_EN
    checkOutput("reset_tlast", ActOut_V_TLAST, 0);
`endif
    ap_rst = 1'b0;
    repeat (2) @(posedge ap_clk);

    // Continuous readiness: 16 bytes 01..10 on consecutive cycles
    applyStimulus(0, 1'b1);
    waitRelease();
    checkOutput("burst_span", lastXferCycle - firstByteCycle, NW * BPW - 1);

    // Sink stalls in a 1,0,0,1 pattern
    applyStimulus(1, 1'b1);
    waitRelease();

    // Token present with value 0 must be ignored
    @(posedge ap_clk);
    #1;
    SyncSig_V        = 1'b0;
    SyncSig_V_ap_vld = 1'b1;
    repeat (10) begin
      @(negedge ap_clk);
      checkOutput("ignored_ce0", ActBuf_Data_ce0, 0);
      checkOutput("ignored_tvalid", ActOut_V_TVALID, 0);
      checkOutput("ignored_ack", SyncSig_V_ap_ack, 0);
    end
    SyncSig_V_ap_vld = 1'b0;

    // Reset after three bytes abandons the buffer without ack
    applyStimulus(0, 1'b1);
    for (int i = 0; i < 100 && bytesSeen < 3; i++) @(negedge ap_clk);
    checkOutput("bytes_before_reset_reached", (bytesSeen >= 3), 1);
    @(posedge ap_clk);
    #1;
    ap_rst           = 1'b1;
    SyncSig_V        = 1'b0;
    SyncSig_V_ap_vld = 1'b0;
    expByteQ.delete();
    expLastQ.delete();
    expAddrQ.delete();
    awaitFirst    = 1'b0;
    lastXferCycle = -100;
    @(posedge ap_clk);
    #1;
    checkOutput("midreset_tvalid", ActOut_V_TVALID, 0);
    checkOutput("midreset_ce0", ActBuf_Data_ce0, 0);
    checkOutput("midreset_ack", SyncSig_V_ap_ack, 0);
    checkOutput("midreset_tdata", ActOut_V_TDATA, 0);
    ap_rst = 1'b0;
    repeat (6) @(posedge ap_clk);

    applyStimulus(0, 1'b1);
    waitRelease();
    checkOutput("restart_burst_span", lastXferCycle - firstByteCycle, NW * BPW - 1);

    // Randomized data under random readiness
    for (int n = 0; n < 4; n++) begin
      applyStimulus(2, 1'b0);
      waitRelease();
      repeat (int'($urandom_range(0, 3))) @(posedge ap_clk);
    end

    applyStimulus(0, 1'b0);
    waitRelease();
    checkOutput("random_burst_span", lastXferCycle - firstByteCycle, NW * BPW - 1);

    repeat (3) @(posedge ap_clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
